// File: rtl/frame_buffer_pkg.sv
// Shared constants for the LED-matrix frame buffer: control-register location,
// memory geometry, RGB565 colours and the Wishbone slave state type.
package frame_buffer_pkg;

    localparam int MATRIX_START = 'h2000;
    localparam int FB_PAGE_SIZE = 'h400;
    localparam int FB_MEM_DEPTH = 2 * FB_PAGE_SIZE;

    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_GREEN = 16'h07E0;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

    // STATUS layout: bit0 = a new page is waiting for frame_start, bit1 = shown page
    function automatic logic [15:0] status_word(input logic pending, input logic page);
        return {14'b0, page, pending};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous pixel RAM: byte-lane write enables, registered read
// (read-before-write on the same address).
module fb_ram #(
    parameter int AW = 11,
    parameter int DW = 16,
    parameter int NB = 2
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [NB-1:0] be,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered frame store: Wishbone classic slave for CPU access plus a
// display read port that always wins the shared RAM port.
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_BYTES    = 2,
    parameter int BASE_ADDRESS  = 0,
    parameter int CTRL_ADDRESS  = MATRIX_START,
    parameter int MEM_DEPTH     = FB_MEM_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    input  logic                     we_i,
    input  logic [DATA_BYTES-1:0]    sel_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    output logic                     ack_o,
    input  logic [2:0]               cti_i,
    input  logic                     frame_start,
    input  logic                     pix_req,
    input  logic [3:0]               pix_row,
    input  logic [4:0]               pix_col,
    output logic [15:0]              pix_data,
    output logic                     pix_valid
);

    localparam int RAM_AW = $clog2(MEM_DEPTH);

    wb_state_e               state;
    logic                    ack_mem;
    logic [DATA_WIDTH-1:0]   ctrl_q;
    logic [DATA_WIDTH-1:0]   active_ptr;
    logic [DATA_WIDTH-1:0]   pending_ptr;
    logic                    pending;

    logic                    mem_hit, fptr_hit, status_hit, accept, ptr_wr;
    logic [ADDRESS_WIDTH-1:0] mem_off;
    logic [DATA_WIDTH-1:0]   pix_sum;
    logic [DATA_WIDTH-1:0]   ctrl_rd_data;
    logic [RAM_AW-1:0]       ram_addr;
    logic [DATA_BYTES-1:0]   ram_be;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    unused_bits;

    assign mem_hit    = (32'(adr_i) >= 32'(BASE_ADDRESS)) &&
                        (32'(adr_i) < 32'(BASE_ADDRESS + MEM_DEPTH));
    assign fptr_hit   = (adr_i == ADDRESS_WIDTH'(CTRL_ADDRESS));
    assign status_hit = (adr_i == ADDRESS_WIDTH'(CTRL_ADDRESS + 1));

    // Control registers never touch the RAM, so only memory hits yield to the display.
    assign accept = (state == WB_IDLE) && cyc_i && stb_i && !rst_i &&
                    (fptr_hit || status_hit || (mem_hit && !pix_req));
    assign ptr_wr = accept && fptr_hit && we_i;

    assign mem_off  = adr_i - ADDRESS_WIDTH'(BASE_ADDRESS);
    assign pix_sum  = (active_ptr >> 1) + DATA_WIDTH'({pix_row, pix_col});
    assign ram_addr = pix_req ? pix_sum[RAM_AW-1:0] : mem_off[RAM_AW-1:0];
    assign ram_be   = (accept && mem_hit && we_i) ? sel_i : '0;

    assign ctrl_rd_data = status_hit ? DATA_WIDTH'(status_word(pending, active_ptr[11]))
                                     : pending_ptr;

    fb_ram #(
        .AW (RAM_AW),
        .DW (DATA_WIDTH),
        .NB (DATA_BYTES)
    ) u_ram (
        .clk   (clk_i),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (dat_i),
        .q     (ram_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= WB_IDLE;
            ack_o       <= 1'b0;
            ack_mem     <= 1'b0;
            ctrl_q      <= '0;
            pix_valid   <= 1'b0;
            active_ptr  <= '0;
            pending_ptr <= '0;
            pending     <= 1'b0;
        end else begin
            ack_o     <= 1'b0;
            pix_valid <= pix_req;
            case (state)
                WB_IDLE: begin
                    if (accept) begin
                        state   <= WB_ACK;
                        ack_o   <= 1'b1;
                        ack_mem <= mem_hit;
                        ctrl_q  <= ctrl_rd_data;
                    end
                end
                default: state <= WB_IDLE;
            endcase
            if (frame_start && pending) begin
                active_ptr <= pending_ptr;
                pending    <= 1'b0;
            end
            // A coincident pointer write lands after the swap and re-arms pending.
            if (ptr_wr) begin
                pending_ptr <= dat_i;
                pending     <= 1'b1;
            end
        end
    end

    assign dat_o    = ack_o ? (ack_mem ? ram_q : ctrl_q) : '0;
    assign pix_data = pix_valid ? ram_q[15:0] : 16'h0000;

    assign unused_bits = ^{cti_i, pix_sum[DATA_WIDTH-1:RAM_AW], mem_off[ADDRESS_WIDTH-1:RAM_AW]};

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: Wishbone and pixel responses are checked by
// negedge monitors against expected queues filled by the driver tasks.
module tb_frame_buffer;
    import frame_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] adr_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        we_i;
    logic [1:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic [2:0]  cti_i;
    logic        frame_start;
    logic        pix_req;
    logic [3:0]  pix_row;
    logic [4:0]  pix_col;
    logic [15:0] pix_data;
    logic        pix_valid;

    logic [15:0] exp_q[$];
    logic [15:0] msk_q[$];
    logic [15:0] pix_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .we_i        (we_i),
        .sel_i       (sel_i),
        .stb_i       (stb_i),
        .cyc_i       (cyc_i),
        .ack_o       (ack_o),
        .cti_i       (cti_i),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Wishbone monitor
    always @(negedge clk) begin
        if (ack_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: ack_o=1 with no transfer outstanding at %0t", $time);
            end else begin
                logic [15:0] e, m;
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                if (m != 16'h0000) check("wb_read_data", dat_o & m, e & m);
            end
        end else begin
            check("dat_o_zero_without_ack", dat_o, 0);
        end
    end

    // Pixel monitor
    always @(negedge clk) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pix_valid: pix_data=0x%0h at %0t", pix_data, $time);
            end else begin
                check("pix_data", pix_data, pix_q.pop_front());
            end
        end
    end

    task automatic wb_cycle(input logic [15:0] adr, input logic w, input logic [15:0] d,
                            input logic [1:0] s, input logic [15:0] e, input logic [15:0] m,
                            output int lat);
        bit got;
        exp_q.push_back(e);
        msk_q.push_back(m);
        @(posedge clk); #1;
        adr_i = adr; we_i = w; dat_i = d; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = ack_o;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: adr 0x%0h got no ack, required one within 20 cycles", adr);
            void'(exp_q.pop_back());
            void'(msk_q.pop_back());
        end
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [15:0] d, input logic [1:0] s);
        int lat;
        wb_cycle(adr, 1'b1, d, s, 16'h0000, 16'h0000, lat);
    endtask

    task automatic wb_read(input logic [15:0] adr, input logic [15:0] e);
        int lat;
        wb_cycle(adr, 1'b0, 16'h0000, 2'b11, e, 16'hFFFF, lat);
    endtask

    task automatic pix_read(input logic [3:0] r, input logic [4:0] c, input logic [15:0] e);
        pix_q.push_back(e);
        @(posedge clk); #1;
        pix_req = 1'b1; pix_row = r; pix_col = c;
        @(posedge clk); #1;
        pix_req = 1'b0;
        @(negedge clk);
        check("pix_valid_at_n_plus_1", pix_valid, 1);
        @(negedge clk);
        check("pix_valid_single_cycle", pix_valid, 0);
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic no_ack(input logic [15:0] adr, input int cycles);
        int acks;
        @(posedge clk); #1;
        adr_i = adr; we_i = 1'b0; sel_i = 2'b11; cyc_i = 1'b1; stb_i = 1'b1;
        acks = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        check("unmapped_no_ack", acks, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of test");
        $fatal(1);
    end

    initial begin
        int lat, acks, consec;
        logic prev;
        rst_i = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = '0;
        stb_i = 1'b0; cyc_i = 1'b0; cti_i = 3'b000; frame_start = 1'b0;
        pix_req = 1'b1; pix_row = '0; pix_col = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", ack_o, 0);
        check("reset_dat_o", dat_o, 0);
        check("reset_pix_valid", pix_valid, 0);
        check("reset_pix_data", pix_data, 0);
        @(posedge clk); #1;
        rst_i = 1'b0; pix_req = 1'b0;

        wb_read(16'h2001, 16'h0000);

        // Basic write/read and ack latency
        wb_cycle(16'h0005, 1'b1, RGB_RED, 2'b11, 16'h0, 16'h0, lat);
        check("write_ack_latency", lat, 2);
        cti_i = 3'b010;
        wb_cycle(16'h0005, 1'b0, 16'h0, 2'b11, RGB_RED, 16'hFFFF, lat);
        check("read_ack_latency", lat, 2);
        cti_i = 3'b111;

        // Byte lanes
        wb_write(16'h0006, 16'h1234, 2'b11);
        wb_write(16'h0006, 16'hABFF, 2'b10);
        wb_read(16'h0006, 16'hAB34);
        wb_cycle(16'h0006, 1'b1, 16'hFFFF, 2'b00, 16'h0, 16'h0, lat);
        check("sel0_write_acked", lat, 2);
        wb_cycle(16'h0006, 1'b0, 16'h0, 2'b00, 16'hAB34, 16'hFFFF, lat);
        cti_i = 3'b000;

        wb_write(16'h0405, RGB_GREEN, 2'b11);
        wb_write(16'h0420, 16'h1111, 2'b11);
        wb_write(16'h0000, 16'hBEEF, 2'b11);
        wb_write(16'h07FF, 16'h7777, 2'b11);
        wb_read(16'h07FF, 16'h7777);

        pix_read(4'd0, 5'd5, RGB_RED);

        // Page flip through FRAME_PTR / STATUS
        wb_write(16'h2000, 16'h0800, 2'b11);
        wb_read(16'h2001, 16'h0001);
        wb_read(16'h2000, 16'h0800);
        frame_pulse();
        wb_read(16'h2001, 16'h0002);
        pix_read(4'd0, 5'd5, RGB_GREEN);
        pix_read(4'd1, 5'd0, 16'h1111);

        // Display holds the RAM for four cycles while a read is pending
        fork
            wb_cycle(16'h0005, 1'b0, 16'h0, 2'b11, RGB_RED, 16'hFFFF, lat);
            begin
                @(posedge clk); #1;
                pix_req = 1'b1; pix_row = 4'd0; pix_col = 5'd5;
                repeat (4) pix_q.push_back(RGB_GREEN);
                repeat (4) @(posedge clk);
                #1 pix_req = 1'b0;
            end
        join
        check("blocked_read_ack_latency", lat, 6);

        no_ack(16'h3000, 10);
        no_ack(16'h0800, 5);

        // Strobe held across several transfers
        repeat (3) begin
            exp_q.push_back(RGB_RED);
            msk_q.push_back(16'hFFFF);
        end
        @(posedge clk); #1;
        adr_i = 16'h0005; we_i = 1'b0; sel_i = 2'b11; cyc_i = 1'b1; stb_i = 1'b1;
        acks = 0; consec = 0; prev = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack_o) acks++;
            if (ack_o && prev) consec++;
            prev = ack_o;
        end
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        check("held_stb_ack_count", acks, 3);
        check("held_stb_back_to_back_acks", consec, 0);

        // Pixel address wraps modulo the memory depth
        wb_write(16'h2000, 16'h0FFE, 2'b11);
        frame_pulse();
        wb_read(16'h2001, 16'h0002);
        pix_read(4'd0, 5'd1, 16'hBEEF);
        wb_write(16'h2001, 16'hFFFF, 2'b11);
        wb_read(16'h2001, 16'h0002);

        // FRAME_PTR write coincident with frame_start
        wb_write(16'h2000, 16'h0800, 2'b11);
        exp_q.push_back(16'h0);
        msk_q.push_back(16'h0);
        @(posedge clk); #1;
        adr_i = 16'h2000; we_i = 1'b1; dat_i = 16'h0000; sel_i = 2'b11;
        cyc_i = 1'b1; stb_i = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("coincident_write_ack", ack_o, 1);
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        wb_read(16'h2001, 16'h0003);
        wb_read(16'h2000, 16'h0000);
        pix_read(4'd0, 5'd5, RGB_GREEN);
        frame_pulse();
        wb_read(16'h2001, 16'h0000);
        pix_read(4'd0, 5'd5, RGB_RED);

        // Reset during a write acceptance cycle
        wb_write(16'h0007, 16'h5555, 2'b11);
        wb_write(16'h2000, 16'h0800, 2'b11);
        @(posedge clk); #1;
        rst_i = 1'b1; adr_i = 16'h0007; we_i = 1'b1; dat_i = 16'hAAAA; sel_i = 2'b11;
        cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        check("reset_write_no_ack", ack_o, 0);
        wb_read(16'h0007, 16'h5555);
        wb_read(16'h2001, 16'h0000);
        wb_read(16'h2000, 16'h0000);

        repeat (3) @(posedge clk);
        check("wb_queue_drained", exp_q.size(), 0);
        check("pix_queue_drained", pix_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, default 16, Wishbone address width; DATA_WIDTH, default 16, data width; DATA_BYTES, default 2, number of select lines; BASE_ADDRESS, default 0, first word of pixel memory; CTRL_ADDRESS, default `MATRIX_START, word address of the FRAME_PTR register; MEM_DEPTH, default 2048, pixel memory words (two 0x400 pages).
REQ-002 SHALL have ports: clk_i  in  1  sole clock; rst_i  in  1  reset (synchronous, active-high); adr_i  in  ADDRESS_WIDTH  word address; dat_i  in  DATA_WIDTH  write data; dat_o  out  DATA_WIDTH  read data; we_i  in  1  write enable; sel_i  in  DATA_BYTES  byte selects; stb_i  in  1  strobe; cyc_i  in  1  cycle; ack_o  out  1  acknowledge; cti_i  in  3  cycle type; frame_start  in  1  display frame-boundary pulse; pix_req  in  1  display read request; pix_row  in  4  pixel row; pix_col  in  5  pixel column; pix_data  out  16  RGB565 pixel; pix_valid  out  1  pix_data qualifier.
REQ-003 SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.

Function
REQ-004 SHALL decode a memory hit when BASE_ADDRESS <= adr_i < BASE_ADDRESS+MEM_DEPTH; a FRAME_PTR hit when adr_i == CTRL_ADDRESS; a STATUS hit when adr_i == CTRL_ADDRESS+1.
REQ-005 SHALL leave unmapped addresses unacknowledged (the master's timeout is the error path); ack_o SHALL be asserted only for hits.
REQ-006 SHALL implement the Wishbone state machine IDLE -> ACK -> IDLE: a transfer is accepted in IDLE when cyc_i & stb_i & hit and no display conflict exists (REQ-012); ack_o is a single-cycle pulse on the cycle after acceptance.
REQ-007 SHALL ignore stb_i in the ACK state, so a held strobe cannot be double-acked; maximum throughput is one transfer per 2 cycles.
REQ-008 SHALL perform memory writes in the acceptance cycle, with byte lane n written only when sel_i[n]=1; sel_i=0 SHALL still be acked with no change to memory.
REQ-009 SHALL present memory read data on dat_o, ignoring sel_i, in the same cycle ack_o is asserted; dat_o SHALL be 0 whenever ack_o=0.
REQ-010 SHALL treat every cti_i value (000, 010, 111) as a classic cycle, acking each beat individually.
REQ-011 SHALL define FRAME_PTR as a byte address of the displayed page: a write stores dat_i into pending_ptr and sets pending=1; a read returns pending_ptr. STATUS SHALL be read-only (bit0=pending, bit1=active_ptr[11], other bits 0); writes to STATUS SHALL be acked and discarded.
REQ-012 SHALL give the display priority: on a cycle where pix_req=1, no Wishbone memory access is accepted and a pending memory access is accepted on the next free cycle; control-register accesses are never blocked; worst-case ack latency is 3 cycles (within MAX_WAIT=8).
REQ-013 SHALL compute pixel word address = (active_ptr >> 1) + {row[3:0], col[4:0]} modulo MEM_DEPTH, and on pix_req at cycle N SHALL drive pix_data and pix_valid=1 for exactly cycle N+1.
REQ-014 SHALL, on frame_start with pending=1, copy pending_ptr to active_ptr and clear pending; with pending=0, active_ptr is unchanged.
REQ-015 SHALL, when a FRAME_PTR write and frame_start coincide, copy the previous pending_ptr to active_ptr, store the new value as pending_ptr, and leave pending=1.
REQ-016 SHALL produce pix_data values that do not depend on whether a Wishbone transfer is in progress.

Reset
REQ-017 SHALL set on rst_i: state IDLE, ack_o=0, dat_o=0, pix_valid=0, pix_data=0, active_ptr=0, pending_ptr=0, pending=0; memory contents are not cleared.
REQ-018 SHALL suppress any write whose acceptance cycle coincides with rst_i, and SHALL drop any outstanding ack.

Structure
REQ-019 SHALL take MATRIX_START, memory depth and page size (0x400) from globals.vh; the colour constants belong in the same shared file.
REQ-020 SHALL instantiate one sub-module, fb_ram: a single-port synchronous 16-bit RAM with per-byte write enables and registered read.

Verification
REQ-021 SHALL check: write 0xF800 to word 0x0005, sel=11 -> ack 1 cycle later; read of 0x0005 -> dat_o=0xF800 with ack.
REQ-022 SHALL check: write 0x1234 then write 0xABFF with sel=10 to the same word -> read returns 0xAB34.
REQ-023 SHALL check: write 0x0800 to FRAME_PTR -> STATUS=0x0001; frame_start -> STATUS=0x0002; pix_req row=0 col=5 -> pix_data=word 0x0405, pix_valid at N+1.
REQ-024 SHALL check: pix_req held high during a Wishbone read -> ack is delayed until pix_req drops and is <= 3 cycles after it drops; pix_data is unaffected.
REQ-025 SHALL check: access to an unmapped address 0x3000 -> no ack for 10 cycles; stb held through ACK -> exactly one ack per acceptance.
REQ-026 SHALL check: FRAME_PTR write coincident with frame_start -> active_ptr=old pending_ptr, pending=1; rst_i mid-write -> ack=0 and memory is unchanged.
